// File: rtl/c2d_pkg.sv
// c2d_pkg: shared types and helpers for the conv2D result collector.
//   c2d_col_state_t : collector FSM state encoding
//   c2d_out_dim()   : valid-convolution output dimension (vec - ker + 1)
//   C2D_DAT_W       : default result word width
package c2d_pkg;

  localparam int unsigned C2D_DAT_W = 16;

  typedef enum logic [1:0] {
    sIDLE    = 2'd0,
    sCOLLECT = 2'd1,
    sDRAIN   = 2'd2,
    sDONE    = 2'd3
  } c2d_col_state_t;

  function automatic int unsigned c2d_out_dim(input int unsigned vec, input int unsigned ker);
    return vec - ker + 1;
  endfunction

endpackage

// File: rtl/c2d_res_ram.sv
// c2d_res_ram: simple dual-port result RAM, block-RAM inferable.
//   iclk          : clock
//   iwe/iwaddr/iwdata : synchronous write port
//   ire/iraddr    : synchronous read request
//   ordata        : read data, valid the cycle after ire
module c2d_res_ram #(
  parameter int unsigned pDEPTH = 676,
  parameter int unsigned pDAT_W = 16,
  parameter int unsigned pADR_W = 10
) (
  input  logic              iclk,
  input  logic              iwe,
  input  logic [pADR_W-1:0] iwaddr,
  input  logic [pDAT_W-1:0] iwdata,
  input  logic              ire,
  input  logic [pADR_W-1:0] iraddr,
  output logic [pDAT_W-1:0] ordata
);

  logic [pDAT_W-1:0] mem [pDEPTH];

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge iclk) begin
    if (iwe) mem[iwaddr] <= iwdata;
    if (ire) ordata <= mem[iraddr];
  end

endmodule

// File: rtl/c2d_result_collector.sv
// c2d_result_collector: stores one conv2D output feature map, then streams it
// out in raster order with end-of-line / end-of-frame markers.
//   iclk, irst_n         : clock, async active-low reset
//   istart               : arms collection of a new frame (sIDLE only)
//   ivalid, idata        : result stream from the MAC array (no backpressure)
//   odata, ovalid, iready: readout stream, valid/ready handshake
//   oeol, olast          : last column of a line / last word of the frame
//   obusy, odone, oerr   : not idle / one-cycle frame-done / sticky protocol error
module c2d_result_collector
  import c2d_pkg::*;
#(
  parameter int unsigned pVEC_X = 28,
  parameter int unsigned pVEC_Y = 28,
  parameter int unsigned pKER_X = 3,
  parameter int unsigned pKER_Y = 3,
  parameter int unsigned pDAT_W = C2D_DAT_W
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              istart,
  input  logic              ivalid,
  input  logic [pDAT_W-1:0] idata,
  output logic [pDAT_W-1:0] odata,
  output logic              ovalid,
  input  logic              iready,
  output logic              oeol,
  output logic              olast,
  output logic              obusy,
  output logic              odone,
  output logic              oerr
);

  localparam int unsigned lpOUT_X = c2d_out_dim(pVEC_X, pKER_X);
  localparam int unsigned lpOUT_Y = c2d_out_dim(pVEC_Y, pKER_Y);
  localparam int unsigned lpOUT_N = lpOUT_X * lpOUT_Y;
  localparam int unsigned lpADR_W = $clog2(lpOUT_N);

  localparam logic [lpADR_W-1:0] lpLAST_ADR = lpADR_W'(lpOUT_N - 1);
  localparam logic [lpADR_W-1:0] lpLAST_COL = lpADR_W'(lpOUT_X - 1);

  c2d_col_state_t state, next_state;

  logic [lpADR_W-1:0] wr_ptr, rd_ptr, rd_col;
  logic               rd_fin;
  logic               pend, pend_eol, pend_last;
  logic               skid_vld, skid_eol, skid_last;
  logic [pDAT_W-1:0]  skid_data;
  logic [pDAT_W-1:0]  ram_q;

  logic start_ok_c, wr_c, wr_last_c, pop_c, fin_c, rd_c, err_c;
  logic [2:0] fill_c;

  // State register.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) state <= sIDLE;
    else         state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      sIDLE:    if (istart)    next_state = sCOLLECT;
      sCOLLECT: if (wr_last_c) next_state = sDRAIN;
      sDRAIN:   if (fin_c)     next_state = sDONE;
      sDONE:                   next_state = sIDLE;
      default:                 next_state = sIDLE;
    endcase
  end

  // Control strobes. A read is issued only if its data is guaranteed a slot
  // in {output register, skid register} even if the next cycle stalls.
  always_comb begin
    start_ok_c = 1'b0;
    wr_c       = 1'b0;
    wr_last_c  = 1'b0;
    pop_c      = ovalid && iready;
    fin_c      = 1'b0;
    rd_c       = 1'b0;
    err_c      = 1'b0;
    fill_c     = 3'(ovalid) + 3'(skid_vld) + 3'(pend);
    start_ok_c = istart && (state == sIDLE);
    wr_c       = ivalid && (state == sCOLLECT);
    wr_last_c  = wr_c && (wr_ptr == lpLAST_ADR);
    fin_c      = pop_c && olast;
    rd_c       = (state == sDRAIN) && !rd_fin && (fill_c <= 3'd1 + 3'(pop_c));
    err_c      = (ivalid && (state != sCOLLECT)) || (istart && (state != sIDLE));
  end

  c2d_res_ram #(
    .pDEPTH (lpOUT_N),
    .pDAT_W (pDAT_W),
    .pADR_W (lpADR_W)
  ) u_ram (
    .iclk   (iclk),
    .iwe    (wr_c),
    .iwaddr (wr_ptr),
    .iwdata (idata),
    .ire    (rd_c),
    .iraddr (rd_ptr),
    .ordata (ram_q)
  );

  // Write/read pointers and column counter; all saturate at the frame end.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_col    <= '0;
      rd_fin    <= 1'b0;
      pend      <= 1'b0;
      pend_eol  <= 1'b0;
      pend_last <= 1'b0;
    end else if (start_ok_c) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_col <= '0;
      rd_fin <= 1'b0;
      pend   <= 1'b0;
    end else begin
      if (wr_c && (wr_ptr != lpLAST_ADR)) wr_ptr <= wr_ptr + lpADR_W'(1);
      pend <= rd_c;
      if (rd_c) begin
        pend_eol  <= (rd_col == lpLAST_COL);
        pend_last <= (rd_ptr == lpLAST_ADR);
        if (rd_ptr == lpLAST_ADR) rd_fin <= 1'b1;
        else                      rd_ptr <= rd_ptr + lpADR_W'(1);
        rd_col <= (rd_col == lpLAST_COL) ? '0 : rd_col + lpADR_W'(1);
      end
    end
  end

  // Output register is the head of a 2-deep queue; skid holds the second word.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      odata     <= '0;
      ovalid    <= 1'b0;
      oeol      <= 1'b0;
      olast     <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_eol  <= 1'b0;
      skid_last <= 1'b0;
      obusy     <= 1'b0;
      odone     <= 1'b0;
      oerr      <= 1'b0;
    end else begin
      case ({pop_c, pend})
        2'b11: begin
          if (skid_vld) begin
            odata     <= skid_data;
            oeol      <= skid_eol;
            olast     <= skid_last;
            skid_data <= ram_q;
            skid_eol  <= pend_eol;
            skid_last <= pend_last;
          end else begin
            odata <= ram_q;
            oeol  <= pend_eol;
            olast <= pend_last;
          end
        end
        2'b10: begin
          if (skid_vld) begin
            odata    <= skid_data;
            oeol     <= skid_eol;
            olast    <= skid_last;
            skid_vld <= 1'b0;
          end else begin
            ovalid <= 1'b0;
            odata  <= '0;
            oeol   <= 1'b0;
            olast  <= 1'b0;
          end
        end
        2'b01: begin
          if (ovalid) begin
            skid_data <= ram_q;
            skid_eol  <= pend_eol;
            skid_last <= pend_last;
            skid_vld  <= 1'b1;
          end else begin
            odata  <= ram_q;
            oeol   <= pend_eol;
            olast  <= pend_last;
            ovalid <= 1'b1;
          end
        end
        default: ;
      endcase
      obusy <= (next_state != sIDLE);
      odone <= fin_c;
      // A simultaneous error wins over the clear from an accepted start.
      if (err_c)           oerr <= 1'b1;
      else if (start_ok_c) oerr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_c2d_result_collector.sv
// tb_c2d_result_collector: self-checking bench for c2d_result_collector using
// a 5x5 map with a 3x3 kernel (3x3 = 9 output words).
module tb_c2d_result_collector;

  localparam int unsigned N  = 9;
  localparam int unsigned NX = 3;

  logic        iclk;
  logic        irst_n;
  logic        istart;
  logic        ivalid;
  logic [15:0] idata;
  logic [15:0] odata;
  logic        ovalid;
  logic        iready;
  logic        oeol;
  logic        olast;
  logic        obusy;
  logic        odone;
  logic        oerr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        rdy;
    logic        v;
    logic [15:0] d;
    logic        eol;
    logic        last;
    logic        done;
    logic        busy;
  } vec_t;

  vec_t tbl [12];

  c2d_result_collector #(
    .pVEC_X (5),
    .pVEC_Y (5),
    .pKER_X (3),
    .pKER_Y (3),
    .pDAT_W (16)
  ) dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .istart (istart),
    .ivalid (ivalid),
    .idata  (idata),
    .odata  (odata),
    .ovalid (ovalid),
    .iready (iready),
    .oeol   (oeol),
    .olast  (olast),
    .obusy  (obusy),
    .odone  (odone),
    .oerr   (oerr)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  function automatic vec_t mk(input logic r, input logic v, input logic [15:0] d,
                              input logic e, input logic l, input logic dn, input logic b);
    vec_t x;
    x.rdy = r; x.v = v; x.d = d; x.eol = e; x.last = l; x.done = dn; x.busy = b;
    return x;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  // Arm a frame and feed N words base..base+N-1; optional gaps and an
  // illegal istart in the middle of collection.
  task automatic collect(input int base, input bit gaps, input bit err_start);
    istart = 1'b1;
    ivalid = 1'b0;
    step();
    istart = 1'b0;
    chk("start_busy", 32'(obusy), 1);
    chk("start_oerr_clear", 32'(oerr), 0);
    for (int i = 0; i < int'(N); i++) begin
      if (gaps && (i % 2 == 1)) begin
        ivalid = 1'b0;
        step();
      end
      ivalid = 1'b1;
      idata  = 16'(base + i);
      istart = err_start && (i == 4);
      step();
      istart = 1'b0;
    end
    ivalid = 1'b0;
    chk("collect_busy", 32'(obusy), 1);
    chk("collect_no_ovalid", 32'(ovalid), 0);
    if (err_start) chk("istart_in_collect_err", 32'(oerr), 1);
  endtask

  // Drain with a model word index; mode 0: ready high, 1: random, 2: toggling.
  task automatic drain(input int base, input int mode, input bit inj);
    int idx = 0;
    int cyc = 0;
    bit hs = 1'b0;
    bit prev_v = 1'b0;
    bit done_seen = 1'b0;
    while (cyc < 100) begin
      if (prev_v && !hs) chk("ovalid_held_on_stall", 32'(ovalid), 1);
      if (ovalid) begin
        if (idx < int'(N)) begin
          chk("drain_data", 32'(odata), 32'(16'(base + idx)));
          chk("drain_eol", 32'(oeol), 32'((idx % int'(NX)) == int'(NX) - 1));
          chk("drain_last", 32'(olast), 32'(idx == int'(N) - 1));
        end else begin
          chk("extra_word", 32'(idx), N - 1);
        end
      end
      if (odone) begin
        chk("done_after_last", 32'(idx), N);
        done_seen = 1'b1;
        break;
      end
      ivalid = inj && (cyc == 3);
      idata  = 16'hdead;
      case (mode)
        0:       iready = 1'b1;
        1:       iready = 1'($urandom_range(1, 0));
        default: iready = ~iready;
      endcase
      hs     = ovalid && iready;
      prev_v = ovalid;
      step();
      cyc++;
      if (hs) idx++;
    end
    ivalid = 1'b0;
    iready = 1'b1;
    chk("drain_completed", 32'(done_seen), 1);
  endtask

  // Called in the odone cycle: checks the pulse is single and FSM idles.
  task automatic finish_frame();
    step();
    chk("done_one_cycle", 32'(odone), 0);
    chk("idle_after_done", 32'(obusy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(1, 0, 16'd0, 0, 0, 0, 1);
    tbl[1]  = mk(1, 1, 16'd1, 0, 0, 0, 1);
    tbl[2]  = mk(1, 1, 16'd2, 0, 0, 0, 1);
    tbl[3]  = mk(1, 1, 16'd3, 1, 0, 0, 1);
    tbl[4]  = mk(1, 1, 16'd4, 0, 0, 0, 1);
    tbl[5]  = mk(1, 1, 16'd5, 0, 0, 0, 1);
    tbl[6]  = mk(1, 1, 16'd6, 1, 0, 0, 1);
    tbl[7]  = mk(1, 1, 16'd7, 0, 0, 0, 1);
    tbl[8]  = mk(1, 1, 16'd8, 0, 0, 0, 1);
    tbl[9]  = mk(1, 1, 16'd9, 1, 1, 0, 1);
    tbl[10] = mk(1, 0, 16'd0, 0, 0, 1, 1);
    tbl[11] = mk(1, 0, 16'd0, 0, 0, 0, 0);

    irst_n = 1'b0;
    istart = 1'b0;
    ivalid = 1'b0;
    idata  = '0;
    iready = 1'b1;
    repeat (2) @(posedge iclk);
    #1;
    chk("rst_odata", 32'(odata), 0);
    chk("rst_ovalid", 32'(ovalid), 0);
    chk("rst_oeol", 32'(oeol), 0);
    chk("rst_olast", 32'(olast), 0);
    chk("rst_obusy", 32'(obusy), 0);
    chk("rst_odone", 32'(odone), 0);
    chk("rst_oerr", 32'(oerr), 0);
    @(negedge iclk);
    irst_n = 1'b1;
    step();

    // Frame 1..9 with ready high: cycle-exact table after sDRAIN entry.
    collect(1, 1'b0, 1'b0);
    for (int r = 0; r < 12; r++) begin
      iready = tbl[r].rdy;
      step();
      chk($sformatf("tbl%0d_ovalid", r), 32'(ovalid), 32'(tbl[r].v));
      if (tbl[r].v) begin
        chk($sformatf("tbl%0d_odata", r), 32'(odata), 32'(tbl[r].d));
        chk($sformatf("tbl%0d_oeol", r), 32'(oeol), 32'(tbl[r].eol));
        chk($sformatf("tbl%0d_olast", r), 32'(olast), 32'(tbl[r].last));
      end
      chk($sformatf("tbl%0d_odone", r), 32'(odone), 32'(tbl[r].done));
      chk($sformatf("tbl%0d_obusy", r), 32'(obusy), 32'(tbl[r].busy));
    end

    // Same frame with random ready.
    collect(1, 1'b0, 1'b0);
    drain(1, 1, 1'b0);
    finish_frame();

    // Gapped collection, toggling ready, then a back-to-back frame.
    collect(20, 1'b1, 1'b0);
    drain(20, 2, 1'b0);
    finish_frame();
    collect(40, 1'b0, 1'b0);
    drain(40, 1, 1'b0);
    finish_frame();
    chk("no_err_back_to_back", 32'(oerr), 0);

    // ivalid in sIDLE: error, word dropped, state stays idle.
    ivalid = 1'b1;
    idata  = 16'hbeef;
    step();
    ivalid = 1'b0;
    chk("idle_ivalid_err", 32'(oerr), 1);
    chk("idle_ivalid_stays_idle", 32'(obusy), 0);
    step();
    chk("err_sticky_idle", 32'(oerr), 1);

    // Start clears the flag; istart mid-collection sets it without disturbing data.
    collect(60, 1'b0, 1'b1);
    drain(60, 0, 1'b0);
    finish_frame();
    chk("err_sticky_frame", 32'(oerr), 1);

    // ivalid during readout: error, readout unaffected.
    collect(80, 1'b1, 1'b0);
    drain(80, 2, 1'b1);
    finish_frame();
    chk("drain_ivalid_err", 32'(oerr), 1);

    // Reset while word 4 is presented, then a clean frame.
    collect(100, 1'b0, 1'b0);
    iready = 1'b1;
    repeat (5) step();
    chk("pre_reset_ovalid", 32'(ovalid), 1);
    chk("pre_reset_word4", 32'(odata), 103);
    #2;
    irst_n = 1'b0;
    #1;
    chk("arst_odata", 32'(odata), 0);
    chk("arst_ovalid", 32'(ovalid), 0);
    chk("arst_oeol", 32'(oeol), 0);
    chk("arst_olast", 32'(olast), 0);
    chk("arst_obusy", 32'(obusy), 0);
    chk("arst_odone", 32'(odone), 0);
    chk("arst_oerr", 32'(oerr), 0);
    @(negedge iclk);
    irst_n = 1'b1;
    step();
    chk("post_reset_idle", 32'(obusy), 0);
    collect(200, 1'b0, 1'b0);
    drain(200, 1, 1'b0);
    finish_frame();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
